dmem_access_unit: RTL and testbench

- Sits directly downstream of the memory stage, between the memory-stage pipeline register outputs and the data-memory port.
- Converts memory-stage load/store requests into a valid/ready request plus response transaction on a word-addressed data bus.
- Generates byte enables and byte-lane-aligned write data, and aligns and sign/zero-extends load data.
- Stalls the whole pipeline until the access completes; this replaces the single-cycle data-memory hookup.

---
 rtl/dmem_pkg.sv | 17 +
 rtl/lsu_lane_align.sv | 60 ++++++
 rtl/dmem_access_unit.sv | 152 +++++++++++++++
 tb/tb_dmem_access_unit.sv | 281 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/dmem_pkg.sv
// Shared funct3 encodings and FSM state type for the data-memory access unit.
package dmem_pkg;

    localparam logic [2:0] F3_B  = 3'b000;
    localparam logic [2:0] F3_H  = 3'b001;
    localparam logic [2:0] F3_W  = 3'b010;
    localparam logic [2:0] F3_BU = 3'b100;
    localparam logic [2:0] F3_HU = 3'b101;

    typedef enum logic [1:0] {
        IDLE,
        REQ,
        WAIT,
        DONE
    } dmem_state_t;

endpackage

// File: rtl/lsu_lane_align.sv
// Combinational lane logic: legality, byte enables, store replication, load extract/extend.
module lsu_lane_align
    import dmem_pkg::*;
#(
    parameter int word_width = 32,
    parameter int be_width   = 4
) (
    input  logic [2:0]            funct3,
    input  logic [1:0]            addr_lo,
    input  logic [word_width-1:0] store_data,
    input  logic [word_width-1:0] load_word,
    output logic                  legal,
    output logic [be_width-1:0]   byte_en,
    output logic [word_width-1:0] store_lanes,
    output logic [word_width-1:0] load_result
);

    logic [word_width-1:0] shifted;

    always_comb begin
        legal       = 1'b0;
        byte_en     = '0;
        store_lanes = store_data;
        load_result = load_word;
        // Bring the addressed lane down to bit 0 before extending.
        shifted     = load_word >> {addr_lo, 3'b000};
        case (funct3)
            F3_B: begin
                legal       = 1'b1;
                byte_en     = be_width'(1) << addr_lo;
                store_lanes = {(word_width/8){store_data[7:0]}};
                load_result = {{(word_width-8){shifted[7]}}, shifted[7:0]};
            end
            F3_BU: begin
                legal       = 1'b1;
                byte_en     = be_width'(1) << addr_lo;
                store_lanes = {(word_width/8){store_data[7:0]}};
                load_result = {{(word_width-8){1'b0}}, shifted[7:0]};
            end
            F3_H: begin
                legal       = ~addr_lo[0];
                byte_en     = be_width'(3) << addr_lo;
                store_lanes = {(word_width/16){store_data[15:0]}};
                load_result = {{(word_width-16){shifted[15]}}, shifted[15:0]};
            end
            F3_HU: begin
                legal       = ~addr_lo[0];
                byte_en     = be_width'(3) << addr_lo;
                store_lanes = {(word_width/16){store_data[15:0]}};
                load_result = {{(word_width-16){1'b0}}, shifted[15:0]};
            end
            F3_W: begin
                legal       = (addr_lo == 2'b00);
                byte_en     = '1;
            end
            default: legal = 1'b0;
        endcase
    end

endmodule

// File: rtl/dmem_access_unit.sv
// Memory-stage load/store to valid/ready data-bus bridge; stalls the pipeline until the access completes.
module dmem_access_unit
    import dmem_pkg::*;
#(
    parameter int word_width = 32,
    parameter int be_width   = 4
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  MemReqM,
    input  logic                  MemWriteM,
    input  logic [2:0]            Funct3M,
    input  logic [word_width-1:0] ALUResultM,
    input  logic [word_width-1:0] WriteDataM,
    output logic [word_width-1:0] ReadDataM,
    output logic                  StallMem,
    output logic                  MisalignM,
    output logic                  mem_req_valid,
    input  logic                  mem_req_ready,
    output logic [word_width-1:0] mem_addr,
    output logic                  mem_we,
    output logic [be_width-1:0]   mem_be,
    output logic [word_width-1:0] mem_wdata,
    input  logic                  mem_rsp_valid,
    input  logic [word_width-1:0] mem_rdata
);

    dmem_state_t           state_q, state_d;
    logic                  valid_q, valid_d;
    logic                  we_q, we_d;
    logic [be_width-1:0]   be_q, be_d;
    logic [word_width-1:0] addr_q, addr_d;
    logic [word_width-1:0] wdata_q, wdata_d;
    logic [word_width-1:0] rdata_q, rdata_d;
    logic                  misalign_q, misalign_d;
    logic [2:0]            funct3_q, funct3_d;
    logic [1:0]            addr_lo_q, addr_lo_d;

    logic [2:0]            al_funct3;
    logic [1:0]            al_addr_lo;
    logic                  al_legal;
    logic [be_width-1:0]   al_be;
    logic [word_width-1:0] al_wdata;
    logic [word_width-1:0] al_rdata;

    // Live request fields while detecting in IDLE; latched ones once the access is in flight.
    always_comb begin
        al_funct3  = funct3_q;
        al_addr_lo = addr_lo_q;
        if (state_q == IDLE) begin
            al_funct3  = Funct3M;
            al_addr_lo = ALUResultM[1:0];
        end
    end

    lsu_lane_align #(
        .word_width(word_width),
        .be_width  (be_width)
    ) u_align (
        .funct3     (al_funct3),
        .addr_lo    (al_addr_lo),
        .store_data (WriteDataM),
        .load_word  (mem_rdata),
        .legal      (al_legal),
        .byte_en    (al_be),
        .store_lanes(al_wdata),
        .load_result(al_rdata)
    );

    always_comb begin
        state_d    = state_q;
        valid_d    = valid_q;
        we_d       = we_q;
        be_d       = be_q;
        addr_d     = addr_q;
        wdata_d    = wdata_q;
        rdata_d    = rdata_q;
        misalign_d = 1'b0;
        funct3_d   = funct3_q;
        addr_lo_d  = addr_lo_q;
        case (state_q)
            IDLE: begin
                if (MemReqM) begin
                    if (al_legal) begin
                        valid_d   = 1'b1;
                        we_d      = MemWriteM;
                        be_d      = al_be;
                        addr_d    = {ALUResultM[word_width-1:2], 2'b00};
                        wdata_d   = al_wdata;
                        funct3_d  = Funct3M;
                        addr_lo_d = ALUResultM[1:0];
                        state_d   = REQ;
                    end else begin
                        misalign_d = 1'b1;
                        rdata_d    = '0;
                        state_d    = DONE;
                    end
                end
            end
            REQ: begin
                if (mem_req_ready) begin
                    valid_d = 1'b0;
                    state_d = we_q ? DONE : WAIT;
                end
            end
            WAIT: begin
                if (mem_rsp_valid) begin
                    rdata_d = al_rdata;
                    state_d = DONE;
                end
            end
            DONE: state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q    <= IDLE;
            valid_q    <= 1'b0;
            we_q       <= 1'b0;
            be_q       <= '0;
            addr_q     <= '0;
            wdata_q    <= '0;
            rdata_q    <= '0;
            misalign_q <= 1'b0;
            funct3_q   <= '0;
            addr_lo_q  <= '0;
        end else begin
            state_q    <= state_d;
            valid_q    <= valid_d;
            we_q       <= we_d;
            be_q       <= be_d;
            addr_q     <= addr_d;
            wdata_q    <= wdata_d;
            rdata_q    <= rdata_d;
            misalign_q <= misalign_d;
            funct3_q   <= funct3_d;
            addr_lo_q  <= addr_lo_d;
        end
    end

    assign StallMem      = ~reset & MemReqM & (state_q != DONE);
    assign ReadDataM     = rdata_q;
    assign MisalignM     = misalign_q;
    assign mem_req_valid = valid_q;
    assign mem_addr      = addr_q;
    assign mem_we        = we_q;
    assign mem_be        = be_q;
    assign mem_wdata     = wdata_q;

endmodule

// File: tb/tb_dmem_access_unit.sv
// Scoreboard bench: stimulus queues expected bus requests and completions; a negedge monitor checks them.
module tb_dmem_access_unit;

    typedef struct {
        logic [31:0] addr;
        logic        we;
        logic [3:0]  be;
        logic [31:0] wdata;
        bit          chk_wd;
    } req_exp_t;

    typedef struct {
        int unsigned stall;
        logic [31:0] rdata;
        logic        mis;
        bit          chk_rd;
    } done_exp_t;

    logic        clk = 1'b0;
    logic        reset;
    logic        MemReqM, MemWriteM;
    logic [2:0]  Funct3M;
    logic [31:0] ALUResultM, WriteDataM, ReadDataM;
    logic        StallMem, MisalignM;
    logic        mem_req_valid, mem_req_ready, mem_we, mem_rsp_valid;
    logic [31:0] mem_addr, mem_wdata, mem_rdata;
    logic [3:0]  mem_be;

    req_exp_t    req_q[$];
    done_exp_t   done_q[$];
    int unsigned checks = 0;
    int unsigned errors = 0;
    int unsigned stall_cnt = 0;
    int unsigned hs_count = 0;

    int unsigned cfg_ready_delay = 0;
    int unsigned cfg_rsp_delay = 0;
    logic [31:0] cfg_rdata = '0;
    bit          manual = 1'b0;

    dmem_access_unit #(.word_width(32), .be_width(4)) dut (
        .clk          (clk),
        .reset        (reset),
        .MemReqM      (MemReqM),
        .MemWriteM    (MemWriteM),
        .Funct3M      (Funct3M),
        .ALUResultM   (ALUResultM),
        .WriteDataM   (WriteDataM),
        .ReadDataM    (ReadDataM),
        .StallMem     (StallMem),
        .MisalignM    (MisalignM),
        .mem_req_valid(mem_req_valid),
        .mem_req_ready(mem_req_ready),
        .mem_addr     (mem_addr),
        .mem_we       (mem_we),
        .mem_be       (mem_be),
        .mem_wdata    (mem_wdata),
        .mem_rsp_valid(mem_rsp_valid),
        .mem_rdata    (mem_rdata)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Memory model: ready after cfg_ready_delay REQ cycles, response on WAIT cycle cfg_rsp_delay.
    initial begin : responder
        bit          hs_ld;
        bit          armed;
        int unsigned rdy_cnt;
        int unsigned rsp_cnt;
        armed = 1'b0;
        rdy_cnt = 0;
        rsp_cnt = 0;
        forever begin
            @(negedge clk);
            hs_ld = mem_req_valid && mem_req_ready && !mem_we;
            @(posedge clk);
            #1;
            if (!manual) begin
                mem_rsp_valid = 1'b0;
                if (hs_ld) begin
                    armed = 1'b1;
                    rsp_cnt = cfg_rsp_delay;
                end
                if (armed) begin
                    if (rsp_cnt == 0) begin
                        mem_rsp_valid = 1'b1;
                        mem_rdata = cfg_rdata;
                        armed = 1'b0;
                    end else begin
                        rsp_cnt--;
                    end
                end
                if (mem_req_valid) begin
                    mem_req_ready = (rdy_cnt >= cfg_ready_delay);
                    rdy_cnt++;
                end else begin
                    mem_req_ready = 1'b0;
                    rdy_cnt = 0;
                end
            end
        end
    end

    always @(negedge clk) begin : monitor
        req_exp_t  re;
        done_exp_t de;
        if (reset) begin
            stall_cnt = 0;
        end else begin
            if (mem_req_valid) begin
                if (req_q.size() == 0) begin
                    chk("unexpected_req_valid", {31'b0, mem_req_valid}, 32'h0);
                end else begin
                    re = req_q[0];
                    chk("mem_addr", mem_addr, re.addr);
                    chk("mem_we", {31'b0, mem_we}, {31'b0, re.we});
                    chk("mem_be", {28'b0, mem_be}, {28'b0, re.be});
                    if (re.chk_wd) chk("mem_wdata", mem_wdata, re.wdata);
                    if (mem_req_ready) begin
                        void'(req_q.pop_front());
                        hs_count++;
                    end
                end
            end
            if (MemReqM && StallMem) begin
                stall_cnt++;
            end else if (MemReqM) begin
                if (done_q.size() == 0) begin
                    chk("unexpected_done", 32'h1, 32'h0);
                end else begin
                    de = done_q.pop_front();
                    chk("stall_cycles", stall_cnt, de.stall);
                    chk("MisalignM", {31'b0, MisalignM}, {31'b0, de.mis});
                    if (de.chk_rd) chk("ReadDataM", ReadDataM, de.rdata);
                end
                stall_cnt = 0;
            end
        end
    end

    // Leaves MemReqM high at exit so a following call starts in the IDLE cycle right after DONE.
    task automatic access(input logic we, input logic [2:0] f3, input logic [31:0] addr,
                          input logic [31:0] wd, input logic [31:0] rdata,
                          input int unsigned rdy_dly, input int unsigned rsp_dly,
                          input logic [3:0] exp_be, input logic [31:0] exp_wd,
                          input int unsigned exp_stall, input logic [31:0] exp_rd,
                          input logic exp_mis);
        int unsigned n;
        cfg_ready_delay = rdy_dly;
        cfg_rsp_delay = rsp_dly;
        cfg_rdata = rdata;
        if (!exp_mis) req_q.push_back('{addr & 32'hFFFF_FFFC, we, exp_be, exp_wd, we});
        done_q.push_back('{exp_stall, exp_rd, exp_mis, (!we || exp_mis)});
        MemReqM = 1'b1;
        MemWriteM = we;
        Funct3M = f3;
        ALUResultM = addr;
        WriteDataM = wd;
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (StallMem && n < 50);
        if (n >= 50) begin
            errors++;
            $display("FAIL access_timeout: got stall after %0d cycles expected completion", n);
        end
        @(posedge clk);
        #1;
    endtask

    task automatic idle(input int unsigned n);
        MemReqM = 1'b0;
        repeat (n) @(posedge clk);
        #1;
    endtask

    initial begin : watchdog
        #200000;
        $display("FAIL watchdog: got no finish expected finish");
        $fatal(1, "watchdog expired");
    end

    initial begin : stimulus
        int unsigned hs0;
        reset = 1'b1;
        MemReqM = 1'b1;
        MemWriteM = 1'b0;
        Funct3M = 3'b010;
        ALUResultM = 32'h100;
        WriteDataM = '0;
        mem_req_ready = 1'b0;
        mem_rsp_valid = 1'b0;
        mem_rdata = '0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("reset_StallMem", {31'b0, StallMem}, 32'h0);
        chk("reset_req_valid", {31'b0, mem_req_valid}, 32'h0);
        chk("reset_ReadDataM", ReadDataM, 32'h0);
        chk("reset_mem_addr", mem_addr, 32'h0);
        chk("reset_mem_be_we", {27'b0, mem_be, mem_we}, 32'h0);
        chk("reset_mem_wdata", mem_wdata, 32'h0);
        chk("reset_MisalignM", {31'b0, MisalignM}, 32'h0);
        @(posedge clk);
        #1;
        reset = 1'b0;
        idle(2);

        //      we    f3      addr        wdata         rdata         rdy rsp be       exp_wd        st exp_rd        mis
        access(1'b1, 3'b010, 32'h100, 32'hDEADBEEF, 32'h0,         0, 0, 4'b1111, 32'hDEADBEEF, 2, 32'h0,         1'b0); idle(1);
        access(1'b1, 3'b000, 32'h103, 32'h000000A5, 32'h0,         0, 0, 4'b1000, 32'hA5A5A5A5, 2, 32'h0,         1'b0); idle(1);
        access(1'b0, 3'b000, 32'h103, 32'h0,        32'hA5000000,  0, 0, 4'b1000, 32'h0,        3, 32'hFFFFFFA5,  1'b0); idle(1);
        access(1'b0, 3'b100, 32'h103, 32'h0,        32'hA5000000,  0, 0, 4'b1000, 32'h0,        3, 32'h000000A5,  1'b0); idle(1);
        access(1'b0, 3'b001, 32'h102, 32'h0,        32'h80010000,  3, 1, 4'b1100, 32'h0,        7, 32'hFFFF8001,  1'b0); idle(1);
        access(1'b0, 3'b101, 32'h102, 32'h0,        32'h80010000,  0, 0, 4'b1100, 32'h0,        3, 32'h00008001,  1'b0); idle(1);
        access(1'b1, 3'b001, 32'h102, 32'h0000BEEF, 32'h0,         1, 0, 4'b1100, 32'hBEEFBEEF, 3, 32'h0,         1'b0); idle(1);
        access(1'b0, 3'b001, 32'h000, 32'h0,        32'h00007FFF,  0, 2, 4'b0011, 32'h0,        5, 32'h00007FFF,  1'b0); idle(1);
        access(1'b0, 3'b000, 32'h101, 32'h0,        32'h00008000,  0, 0, 4'b0010, 32'h0,        3, 32'hFFFFFF80,  1'b0); idle(1);
        access(1'b0, 3'b010, 32'h101, 32'h0,        32'h0,         0, 0, 4'b0000, 32'h0,        1, 32'h0,         1'b1); idle(1);
        access(1'b1, 3'b001, 32'h103, 32'h1234,     32'h0,         0, 0, 4'b0000, 32'h0,        1, 32'h0,         1'b1); idle(1);
        access(1'b0, 3'b011, 32'h100, 32'h0,        32'h0,         0, 0, 4'b0000, 32'h0,        1, 32'h0,         1'b1); idle(1);

        hs0 = hs_count;
        access(1'b1, 3'b010, 32'h104, 32'h12345678, 32'h0,         0, 0, 4'b1111, 32'h12345678, 2, 32'h0,         1'b0);
        access(1'b0, 3'b010, 32'h104, 32'h0,        32'hCAFEF00D,  0, 0, 4'b1111, 32'h0,        3, 32'hCAFEF00D,  1'b0);
        idle(1);
        chk("back_to_back_handshakes", hs_count - hs0, 32'd2);

        manual = 1'b1;
        req_q.push_back('{32'h200, 1'b0, 4'b1111, 32'h0, 1'b0});
        mem_req_ready = 1'b1;
        mem_rsp_valid = 1'b0;
        MemReqM = 1'b1;
        MemWriteM = 1'b0;
        Funct3M = 3'b010;
        ALUResultM = 32'h200;
        @(posedge clk);
        #1;
        @(posedge clk);
        #1;
        mem_req_ready = 1'b0;
        reset = 1'b1;
        @(negedge clk);
        chk("reset_in_wait_StallMem", {31'b0, StallMem}, 32'h0);
        @(posedge clk);
        #1;
        reset = 1'b0;
        MemReqM = 1'b0;
        mem_rsp_valid = 1'b1;
        mem_rdata = 32'h12345678;
        @(negedge clk);
        chk("late_rsp_StallMem", {31'b0, StallMem}, 32'h0);
        chk("late_rsp_req_valid", {31'b0, mem_req_valid}, 32'h0);
        @(posedge clk);
        #1;
        mem_rsp_valid = 1'b0;
        @(negedge clk);
        chk("late_rsp_ReadDataM", ReadDataM, 32'h0);
        chk("late_rsp_MisalignM", {31'b0, MisalignM}, 32'h0);
        @(posedge clk);
        #1;
        manual = 1'b0;
        idle(1);

        access(1'b1, 3'b010, 32'h010, 32'h00000001, 32'h0,         0, 0, 4'b1111, 32'h00000001, 2, 32'h0,         1'b0); idle(3);

        chk("req_queue_drained", req_q.size(), 32'd0);
        chk("done_queue_drained", done_q.size(), 32'd0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
